fetch_flow_control: RTL and testbench
=====================================

Name: fetch_flow_control

Overview:
- Fetch-and-flow stage that sits directly after the program counter.
- Drives the program ROM address from the current PC and receives the synchronous ROM's data.
- Decodes program-flow opcodes (GOTO, BZ, BNZ, CALL, RET) and drives the PC's write-enable, add-offset and address inputs.
- Forwards all other instructions, with a valid flag, to the execute stage. Squashes the one wrong-path slot after every taken flow change and maintains a hardware return stack.

Parameters:
- PC_WIDTH, 8, width of PC, ROM address, immediate and return-stack entries.
- INSTR_WIDTH, 16, instruction width; opcode in [15:12], immediate in [PC_WIDTH-1:0].
- STACK_DEPTH, 4, number of return-stack entries (power of 2, at least 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- res  in  1  synchronous, active-high reset.
- pc_in  in  PC_WIDTH  current PC value. The PC resets to all-ones and increments each cycle unless pc_wr_en is high.
- rom_addr  out  PC_WIDTH  ROM address, equal to pc_in (combinational).
- rom_data  in  INSTR_WIDTH  ROM output; data for the address presented in the previous cycle.
- zero_flag  in  1  ALU zero flag, sampled in the decode cycle.
- pc_wr_en  out  1  PC load request.
- pc_add_offset  out  1  1 means the PC adds pc_value; 0 means the PC loads pc_value.
- pc_value  out  PC_WIDTH  target address or offset.
- instr_out  out  INSTR_WIDTH  rom_data passed through to execute.
- instr_valid  out  1  instr_out is a valid non-flow instruction.
- stack_ovf  out  1  sticky: CALL issued while the stack was full.
- stack_unf  out  1  sticky: RET issued while the stack was empty.

Behaviour:
- Reset (res=1 at an edge):
  - vld_q=0, boot_q=1, sp=0, stack_ovf=0, stack_unf=0.
  - All outputs are 0 while in reset.
  - Stack contents are don't-care.
  - Reset mid-operation aborts any pending flow change; no push or pop occurs on that edge.
- Registers:
  - addr_q <= pc_in every cycle; addr_q is the address of the current rom_data.
  - vld_q <= !boot_q && !take.
  - boot_q <= 0.
  - The boot cycle discards the fetch of address all-ones that occurs immediately after reset.
- Decode:
  - Active only when vld_q=1; when vld_q=0, all pc_* outputs are 0 and instr_valid=0.
  - op = rom_data[15:12], imm = rom_data[PC_WIDTH-1:0], A = addr_q.
  - 0x8 GOTO: take; pc_add_offset=0; pc_value=imm.
  - 0x9 BZ: take if zero_flag=1; pc_add_offset=1; pc_value=imm-1 (mod 2^PC_WIDTH).
  - 0xA BNZ: as BZ but taken if zero_flag=0.
  - BZ/BNZ target is A+imm, with imm two's-complement. Because pc_in=A+1 in the decode cycle, the offset sent is imm-1. Wrap-around is modulo 2^PC_WIDTH.
  - 0xB CALL: take; push A+1; pc_add_offset=0; pc_value=imm. If sp==STACK_DEPTH: no push, stack_ovf<=1, jump still taken.
  - 0xC RET: if sp>0, pop and take with pc_add_offset=0 and pc_value=top entry. If sp==0: not taken, stack_unf<=1.
  - All other opcodes: instr_valid=1, no PC write.
- Flow opcodes (0x8-0xC) never assert instr_valid, whether taken or not.
- pc_wr_en = take (combinational from vld_q, rom_data and zero_flag).
- Latency and penalty:
  - A taken flow loads the PC on the same edge that ends its decode cycle.
  - The next slot (address A+1) is squashed via vld_q=0; the target instruction decodes two cycles after the flow instruction.
  - Penalty is 1 bubble; a not-taken branch has no penalty.
- Back-to-back taken flows are impossible, because the slot after a taken flow is always invalid.
- Stack pointer: range 0..STACK_DEPTH, changes by at most ±1 per cycle, and never over- or underflows internally.

Test Plan:
- Reset, release, with ROM holding NOPs (op 0x0) -> instr_valid=0 for the first 2 cycles after release, then 1 with addr_q=0x00, 0x01, 0x02 in consecutive cycles.
- GOTO 0x40 at address 0x05 -> pc_wr_en=1, pc_add_offset=0, pc_value=0x40 in its decode cycle; the slot for 0x06 is squashed; next valid addr_q=0x40.
- BZ imm=0xFD at 0x10 with zero_flag=1 -> pc_add_offset=1, pc_value=0xFC, next valid addr_q=0x0D. Same with zero_flag=0 -> no pc_wr_en, next valid addr_q=0x11.
- BNZ imm=0x05 at 0xFE with zero_flag=0 -> target 0x03 (wrap-around), pc_value=0x04.
- CALL 0x20 at 0x08, then RET at 0x20 -> return stack pushes 0x09; RET drives pc_value=0x09 with pc_add_offset=0; next valid addr_q=0x09.
- Five nested CALLs with STACK_DEPTH=4 -> stack_ovf=1 after the fifth, which still jumps. Then RET with an empty stack -> stack_unf=1, no pc_wr_en, and res=1 clears both flags.

Source files
------------

// File: rtl/fetch_flow_control.sv
// Fetch/flow stage: drives ROM address from PC, decodes GOTO/BZ/BNZ/CALL/RET into PC loads, forwards the rest.
// Decode is one cycle after fetch; a taken flow costs one squashed slot; no backpressure.
module fetch_flow_control #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [PC_WIDTH-1:0]    pc_in,
    output logic [PC_WIDTH-1:0]    rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   zero_flag,
    output logic                   pc_wr_en,
    output logic                   pc_add_offset,
    output logic [PC_WIDTH-1:0]    pc_value,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   instr_valid,
    output logic                   stack_ovf,
    output logic                   stack_unf
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    localparam logic [3:0] OP_GOTO = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BNZ  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;

    logic [PC_WIDTH-1:0] r_addr;
    logic                r_vld;
    logic                r_boot;
    logic [SP_W-1:0]     r_sp;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];
    logic                r_ovf;
    logic                r_unf;

    logic [3:0]          w_op;
    logic [PC_WIDTH-1:0] w_imm;
    logic                w_full;
    logic                w_empty;
    logic [IDX_W-1:0]    w_push_idx;
    logic [IDX_W-1:0]    w_top_idx;
    logic                w_take;
    logic                w_add;
    logic [PC_WIDTH-1:0] w_value;
    logic                w_flow;
    logic                w_push;
    logic                w_pop;
    logic                w_set_ovf;
    logic                w_set_unf;

    assign w_op       = rom_data[INSTR_WIDTH-1:INSTR_WIDTH-4];
    assign w_imm      = rom_data[PC_WIDTH-1:0];
    assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty    = (r_sp == '0);
    assign w_push_idx = IDX_W'(r_sp);
    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));

    always_comb begin
        w_take    = 1'b0;
        w_add     = 1'b0;
        w_value   = '0;
        w_flow    = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        if (r_vld && !res) begin
            case (w_op)
                OP_GOTO: begin
                    w_flow  = 1'b1;
                    w_take  = 1'b1;
                    w_value = w_imm;
                end
                // pc_in is already A+1 here, so the relative offset is one short
                OP_BZ, OP_BNZ: begin
                    w_flow  = 1'b1;
                    w_add   = 1'b1;
                    w_value = w_imm - PC_WIDTH'(1);
                    w_take  = (w_op == OP_BZ) ? zero_flag : !zero_flag;
                end
                OP_CALL: begin
                    w_flow    = 1'b1;
                    w_take    = 1'b1;
                    w_value   = w_imm;
                    w_push    = !w_full;
                    w_set_ovf = w_full;
                end
                OP_RET: begin
                    w_flow    = 1'b1;
                    w_take    = !w_empty;
                    w_pop     = !w_empty;
                    w_value   = w_empty ? '0 : r_stack[w_top_idx];
                    w_set_unf = w_empty;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_addr <= pc_in;
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_vld  <= 1'b0;
            r_boot <= 1'b1;
            r_sp   <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
        end else begin
            r_vld  <= !r_boot && !w_take;
            r_boot <= 1'b0;
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SP_W'(1);
            end
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
        end
    end

    // Stack contents need no reset; w_push is already qualified by !res
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= r_addr + PC_WIDTH'(1);
        end
    end

    assign rom_addr      = res ? '0 : pc_in;
    assign pc_wr_en      = w_take;
    assign pc_add_offset = w_take ? w_add : (w_flow ? w_add : 1'b0);
    assign pc_value      = w_value;
    assign instr_out     = res ? '0 : rom_data;
    assign instr_valid   = r_vld && !res && !w_flow;
    assign stack_ovf     = r_ovf && !res;
    assign stack_unf     = r_unf && !res;
endmodule

// File: tb/tb_fetch_flow_control.sv
// Bench for fetch_flow_control: PC/ROM environment, decode vector table, hand sequences, random run vs program-level model.
module tb_fetch_flow_control;
    localparam int PW = 8;
    localparam int IW = 16;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          res = 1'b1;
    logic          zero_flag = 1'b0;
    logic [PW-1:0] pc_in = '1;
    logic [PW-1:0] rom_addr;
    logic [IW-1:0] rom_data = '0;
    logic          pc_wr_en;
    logic          pc_add_offset;
    logic [PW-1:0] pc_value;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          stack_ovf;
    logic          stack_unf;

    logic [IW-1:0] rom [256];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_flow_control #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .STACK_DEPTH(SD)) dut (
        .clk(clk), .res(res), .pc_in(pc_in), .rom_addr(rom_addr), .rom_data(rom_data),
        .zero_flag(zero_flag), .pc_wr_en(pc_wr_en), .pc_add_offset(pc_add_offset),
        .pc_value(pc_value), .instr_out(instr_out), .instr_valid(instr_valid),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    // Program counter and synchronous ROM around the stage
    always @(posedge clk) begin
        if (res) pc_in <= '1;
        else if (pc_wr_en) pc_in <= pc_add_offset ? pc_in + pc_value : pc_value;
        else pc_in <= pc_in + 8'd1;
        rom_data <= rom[rom_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic init_rom();
        for (int i = 0; i < 256; i++) rom[i] = {8'h00, 8'(i)};
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1;
        #1;
        chk("rst_addr", rom_addr, 0);
        chk("rst_wr", pc_wr_en, 0);
        chk("rst_add", pc_add_offset, 0);
        chk("rst_val", pc_value, 0);
        chk("rst_instr", instr_out, 0);
        chk("rst_vld", instr_valid, 0);
        chk("rst_ovf", stack_ovf, 0);
        chk("rst_unf", stack_unf, 0);
        repeat (2) @(negedge clk);
        res = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] instr;
        logic        zf;
        logic        exp_wr;
        logic        exp_add;
        logic [7:0]  exp_val;
        logic        exp_valid;
        logic [7:0]  exp_next;
        int          exp_gap;
    } vec_t;
    vec_t tbl [9];

    initial begin
        int gap;
        logic [7:0] rets [4];
        int wait_n;
        logic [7:0] nxt, a, imm, tgt, offs;
        logic [15:0] ins;
        logic [3:0] op;
        logic tk, flow, m_ovf, m_unf;
        logic [7:0] stk [$];

        tbl[0] = '{8'h05, 16'h8040, 1'b0, 1'b1, 1'b0, 8'h40, 1'b0, 8'h40, 2};
        tbl[1] = '{8'h10, 16'h90FD, 1'b1, 1'b1, 1'b1, 8'hFC, 1'b0, 8'h0D, 2};
        tbl[2] = '{8'h10, 16'h90FD, 1'b0, 1'b0, 1'b1, 8'hFC, 1'b0, 8'h11, 1};
        tbl[3] = '{8'hFE, 16'hA005, 1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 8'h03, 2};
        tbl[4] = '{8'hFE, 16'hA005, 1'b1, 1'b0, 1'b1, 8'h04, 1'b0, 8'hFF, 1};
        tbl[5] = '{8'h08, 16'hB020, 1'b0, 1'b1, 1'b0, 8'h20, 1'b0, 8'h20, 2};
        tbl[6] = '{8'h33, 16'h7234, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h34, 1};
        tbl[7] = '{8'h20, 16'hC000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h21, 1};
        tbl[8] = '{8'h40, 16'hF0AA, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h41, 1};

        // Boot: two dead slots, then addresses 0,1,2
        init_rom();
        do_reset();
        chk("boot_c0_vld", instr_valid, 0);
        tick();
        chk("boot_c1_vld", instr_valid, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("boot_a%0d_vld", k), instr_valid, 1);
            chk($sformatf("boot_a%0d_ins", k), instr_out, k);
        end

        // Table: GOTO at 0 lands on the vector's address, which decodes at c4
        for (int i = 0; i < 9; i++) begin
            init_rom();
            rom[0] = {8'h80, tbl[i].addr};
            rom[tbl[i].addr] = tbl[i].instr;
            zero_flag = 1'b0;
            do_reset();
            repeat (4) tick();
            zero_flag = tbl[i].zf;
            #1;
            chk($sformatf("tbl%0d_wr", i), pc_wr_en, tbl[i].exp_wr);
            chk($sformatf("tbl%0d_vld", i), instr_valid, tbl[i].exp_valid);
            if (tbl[i].exp_wr) begin
                chk($sformatf("tbl%0d_add", i), pc_add_offset, tbl[i].exp_add);
                chk($sformatf("tbl%0d_val", i), pc_value, tbl[i].exp_val);
            end
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_ins", i), instr_out, tbl[i].instr);
            gap = 0;
            for (int g = 1; g <= 3; g++) begin
                tick();
                if (instr_valid) begin
                    gap = g;
                    break;
                end
            end
            chk($sformatf("tbl%0d_gap", i), gap, tbl[i].exp_gap);
            chk($sformatf("tbl%0d_next", i), instr_out[7:0], tbl[i].exp_next);
        end

        // CALL 0x20 at 0x08, RET at 0x20
        init_rom();
        rom[8'h08] = 16'hB020;
        rom[8'h20] = 16'hC000;
        zero_flag = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("call_wr", pc_wr_en, 1);
        chk("call_add", pc_add_offset, 0);
        chk("call_val", pc_value, 8'h20);
        tick();
        chk("call_bub", instr_valid, 0);
        tick();
        chk("ret_wr", pc_wr_en, 1);
        chk("ret_add", pc_add_offset, 0);
        chk("ret_val", pc_value, 8'h09);
        tick();
        chk("ret_bub", instr_valid, 0);
        tick();
        chk("ret_land_vld", instr_valid, 1);
        chk("ret_land_ins", instr_out, 16'h0009);

        // Five nested CALLs overflow, four RETs unwind, fifth RET underflows
        init_rom();
        rom[8'h00] = 16'hB010;
        rom[8'h10] = 16'hB020;
        rom[8'h20] = 16'hB030;
        rom[8'h30] = 16'hB040;
        rom[8'h40] = 16'hB050;
        rom[8'h51] = 16'hC000;
        rom[8'h31] = 16'hC000;
        rom[8'h21] = 16'hC000;
        rom[8'h11] = 16'hC000;
        rom[8'h01] = 16'hC000;
        do_reset();
        repeat (10) tick();
        chk("nest5_ovf_pre", stack_ovf, 0);
        chk("nest5_wr", pc_wr_en, 1);
        chk("nest5_val", pc_value, 8'h50);
        tick();
        chk("nest5_ovf", stack_ovf, 1);
        tick();
        chk("nest_land", instr_out, 16'h0050);
        rets[0] = 8'h31; rets[1] = 8'h21; rets[2] = 8'h11; rets[3] = 8'h01;
        for (int r = 0; r < 4; r++) begin
            tick();
            chk($sformatf("unwind%0d_wr", r), pc_wr_en, 1);
            chk($sformatf("unwind%0d_val", r), pc_value, rets[r]);
            tick();
        end
        tick();
        chk("unf_wr", pc_wr_en, 0);
        chk("unf_vld", instr_valid, 0);
        chk("unf_pre", stack_unf, 0);
        tick();
        chk("unf_flag", stack_unf, 1);
        chk("unf_next", instr_out, 16'h0002);
        chk("unf_ovf_kept", stack_ovf, 1);
        do_reset();
        chk("clr_ovf", stack_ovf, 0);
        chk("clr_unf", stack_unf, 0);

        // Random program against a program-level model
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        do_reset();
        wait_n = 2; nxt = 8'h00; stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            zero_flag = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_ovf", stack_ovf, m_ovf);
            chk("rnd_unf", stack_unf, m_unf);
            if (wait_n > 0) begin
                chk("rnd_bub_vld", instr_valid, 0);
                chk("rnd_bub_wr", pc_wr_en, 0);
                wait_n--;
            end else begin
                a = nxt; ins = rom[a]; op = ins[15:12]; imm = ins[7:0];
                tk = 1'b0; tgt = a + 8'd1;
                flow = (op >= 4'h8 && op <= 4'hC);
                case (op)
                    4'h8: begin tk = 1'b1; tgt = imm; end
                    4'h9: begin tk = zero_flag;  tgt = a + imm; end
                    4'hA: begin tk = !zero_flag; tgt = a + imm; end
                    4'hB: begin
                        tk = 1'b1; tgt = imm;
                        if (stk.size() == SD) m_ovf = 1'b1;
                        else stk.push_back(a + 8'd1);
                    end
                    4'hC: begin
                        if (stk.size() > 0) begin tk = 1'b1; tgt = stk.pop_back(); end
                        else m_unf = 1'b1;
                    end
                    default: ;
                endcase
                chk("rnd_wr", pc_wr_en, tk);
                chk("rnd_vld", instr_valid, !flow);
                if (!flow) chk("rnd_ins", instr_out, ins);
                if (tk) begin
                    if (op == 4'h9 || op == 4'hA) begin
                        offs = imm - 8'd1;
                        chk("rnd_add", pc_add_offset, 1);
                        chk("rnd_off", pc_value, offs);
                    end else begin
                        chk("rnd_add", pc_add_offset, 0);
                        chk("rnd_tgt", pc_value, tgt);
                    end
                    wait_n = 1;
                    nxt = tgt;
                end else begin
                    nxt = a + 8'd1;
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
